// File: rtl/eth_rx_frame_writer.sv
// eth_rx_frame_writer: 8-bit AXI-Stream receive path to a 16-bit byte-lane
// frame buffer write port. Frames go into 2 KiB slots. Committed frames are
// published as a (slot, length) descriptor queue.
module eth_rx_frame_writer #(
  parameter int unsigned SLOT_BITS      = 3,
  parameter int unsigned SLOT_WORD_BITS = 10,
  parameter int unsigned MAX_BYTES      = 2048
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          rx_tdata,
  input  logic                                rx_tvalid,
  input  logic                                rx_tlast,
  input  logic                                rx_tuser,
  output logic                                ram_en,
  output logic [1:0]                          ram_we,
  output logic [SLOT_BITS+SLOT_WORD_BITS-1:0] ram_addr,
  output logic [15:0]                         ram_din,
  output logic                                frame_avail,
  output logic [SLOT_BITS-1:0]                frame_slot,
  output logic [SLOT_WORD_BITS+1:0]           frame_len,
  input  logic                                frame_ack,
  output logic [15:0]                         drop_cnt,
  output logic [15:0]                         err_cnt
);

  localparam int unsigned ADDR_W = SLOT_BITS + SLOT_WORD_BITS;
  localparam int unsigned N_W    = SLOT_WORD_BITS + 2;
  localparam int unsigned NSLOT  = 1 << SLOT_BITS;
  localparam int unsigned CNT_W  = SLOT_BITS + 1;

  typedef enum logic [1:0] {SYNC, IDLE, RECV, DROP} state_t;

  state_t                state_q, state_d;
  logic [SLOT_BITS-1:0]  wr_slot_q, wr_slot_d;
  logic [SLOT_BITS-1:0]  rd_slot_q, rd_slot_d;
  logic [N_W-1:0]        n_q, n_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pend_q, pend_d;
  logic [SLOT_BITS-1:0]  pend_slot_q, pend_slot_d;
  logic [N_W-1:0]        pend_len_q, pend_len_d;
  logic [N_W-1:0]        len_q [NSLOT];
  logic [N_W-1:0]        len_d [NSLOT];
  logic                  ram_en_q, ram_en_d;
  logic [1:0]            ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic [15:0]           ram_din_q, ram_din_d;
  logic                  frame_avail_q, frame_avail_d;
  logic [N_W-1:0]        frame_len_q, frame_len_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic [15:0]           err_cnt_q, err_cnt_d;

  logic                    wr_go;
  logic                    fin_go;
  logic [SLOT_WORD_BITS:0] wr_idx;
  logic                    pop;

  // Next-state, write-port and descriptor-queue logic
  always_comb begin
    state_d       = state_q;
    wr_slot_d     = wr_slot_q;
    rd_slot_d     = rd_slot_q;
    n_d           = n_q;
    count_d       = count_q;
    pend_d        = 1'b0;
    pend_slot_d   = pend_slot_q;
    pend_len_d    = pend_len_q;
    len_d         = len_q;
    ram_en_d      = 1'b0;
    ram_we_d      = 2'b00;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    drop_cnt_d    = drop_cnt_q;
    err_cnt_d     = err_cnt_q;
    wr_go         = 1'b0;
    fin_go        = 1'b0;
    wr_idx        = n_q[SLOT_WORD_BITS:0];
    pop           = frame_ack && frame_avail_q;

    case (state_q)
      SYNC: begin
        if (rx_tvalid && rx_tlast) state_d = IDLE;
      end
      IDLE: begin
        if (rx_tvalid) begin
          // A pending commit already owns a slot, so it counts as occupied
          if ((count_q + CNT_W'(pend_q)) == CNT_W'(NSLOT)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
            state_d    = rx_tlast ? IDLE : DROP;
          end else begin
            wr_go  = 1'b1;
            wr_idx = '0;
            n_d    = N_W'(1);
            state_d = RECV;
            if (rx_tlast) fin_go = 1'b1;
          end
        end
      end
      RECV: begin
        if (rx_tvalid) begin
          if (n_q == N_W'(MAX_BYTES)) begin
            err_cnt_d = err_cnt_q + 16'd1;
            state_d   = rx_tlast ? IDLE : DROP;
          end else begin
            wr_go = 1'b1;
            n_d   = n_q + N_W'(1);
            if (rx_tlast) fin_go = 1'b1;
          end
        end
      end
      DROP: begin
        if (rx_tvalid && rx_tlast) state_d = IDLE;
      end
      default: state_d = SYNC;
    endcase

    if (wr_go) begin
      ram_en_d   = 1'b1;
      ram_we_d   = wr_idx[0] ? 2'b10 : 2'b01;
      ram_addr_d = {wr_slot_q, wr_idx[SLOT_WORD_BITS:1]};
      ram_din_d  = {rx_tdata, rx_tdata};
    end

    // Commit is deferred one cycle so it lands with the last byte write
    if (fin_go) begin
      state_d = IDLE;
      if (rx_tuser) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        pend_d      = 1'b1;
        pend_slot_d = wr_slot_q;
        pend_len_d  = N_W'(wr_idx) + N_W'(1);
        wr_slot_d   = wr_slot_q + SLOT_BITS'(1);
      end
    end

    if (pend_q) len_d[pend_slot_q] = pend_len_q;
    rd_slot_d     = rd_slot_q + SLOT_BITS'(pop);
    count_d       = count_q + CNT_W'(pend_q) - CNT_W'(pop);
    frame_avail_d = (count_d != '0);
    frame_len_d   = len_d[rd_slot_d];
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SYNC;
      wr_slot_q     <= '0;
      rd_slot_q     <= '0;
      n_q           <= '0;
      count_q       <= '0;
      pend_q        <= 1'b0;
      pend_slot_q   <= '0;
      pend_len_q    <= '0;
      for (int i = 0; i < int'(NSLOT); i++) len_q[i] <= '0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 2'b00;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      frame_avail_q <= 1'b0;
      frame_len_q   <= '0;
      drop_cnt_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_slot_q     <= wr_slot_d;
      rd_slot_q     <= rd_slot_d;
      n_q           <= n_d;
      count_q       <= count_d;
      pend_q        <= pend_d;
      pend_slot_q   <= pend_slot_d;
      pend_len_q    <= pend_len_d;
      len_q         <= len_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      frame_avail_q <= frame_avail_d;
      frame_len_q   <= frame_len_d;
      drop_cnt_q    <= drop_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign frame_avail = frame_avail_q;
  assign frame_slot  = rd_slot_q;
  assign frame_len   = frame_len_q;
  assign drop_cnt    = drop_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Directed bench for eth_rx_frame_writer with hand-computed expectations.
module tb_eth_rx_frame_writer;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tlast;
  logic        rx_tuser;
  logic        ram_en;
  logic [1:0]  ram_we;
  logic [12:0] ram_addr;
  logic [15:0] ram_din;
  logic        frame_avail;
  logic [2:0]  frame_slot;
  logic [11:0] frame_len;
  logic        frame_ack;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  int errors = 0;
  int checks = 0;

  logic [12:0] log_addr [$];
  logic [1:0]  log_we   [$];
  logic [15:0] log_din  [$];

  eth_rx_frame_writer dut (
    .clk(clk), .rst(rst),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .frame_avail(frame_avail), .frame_slot(frame_slot), .frame_len(frame_len),
    .frame_ack(frame_ack), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every issued buffer write
  always @(negedge clk) begin
    if (ram_en) begin
      log_addr.push_back(ram_addr);
      log_we.push_back(ram_we);
      log_din.push_back(ram_din);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic user);
    @(negedge clk);
    rx_tvalid = 1'b1;
    rx_tdata  = d;
    rx_tlast  = last;
    rx_tuser  = user;
  endtask

  task automatic send_frame(input int nbytes, input logic user);
    for (int i = 0; i < nbytes; i++)
      send(8'(i), i == nbytes - 1, user && (i == nbytes - 1));
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      rx_tuser  = 1'b0;
    end
    #1;
  endtask

  task automatic ack_once();
    @(negedge clk);
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_din.delete();
  endtask

  task automatic chk_zero(input string ctx);
    chk({ctx, " ram_en"},      32'(ram_en),      32'd0);
    chk({ctx, " ram_we"},      32'(ram_we),      32'd0);
    chk({ctx, " ram_addr"},    32'(ram_addr),    32'd0);
    chk({ctx, " ram_din"},     32'(ram_din),     32'd0);
    chk({ctx, " frame_avail"}, 32'(frame_avail), 32'd0);
    chk({ctx, " frame_slot"},  32'(frame_slot),  32'd0);
    chk({ctx, " frame_len"},   32'(frame_len),   32'd0);
    chk({ctx, " drop_cnt"},    32'(drop_cnt),    32'd0);
    chk({ctx, " err_cnt"},     32'(err_cnt),     32'd0);
  endtask

  initial begin
    rst = 1'b1; rx_tvalid = 1'b0; rx_tdata = '0; rx_tlast = 1'b0; rx_tuser = 1'b0; frame_ack = 1'b0;
    #1;
    chk_zero("reset");
    idle_cyc(3);
    @(negedge clk); rst = 1'b0;

    // SYNC swallows a partial frame up to its tlast
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    idle_cyc(3);
    chk("sync writes", 32'(log_addr.size()), 32'd0);
    chk("sync avail",  32'(frame_avail),     32'd0);

    // 1-byte frame
    send(8'hA5, 1'b1, 1'b0);
    idle_cyc(1);
    chk("b1 ram_en t+1",  32'(ram_en),           32'd1);
    chk("b1 writes",      32'(log_addr.size()),  32'd1);
    if (log_addr.size() > 0) begin
      chk("b1 addr", 32'(log_addr[0]), 32'h0000);
      chk("b1 we",   32'(log_we[0]),   32'd1);
      chk("b1 din",  32'(log_din[0]),  32'hA5A5);
    end
    chk("b1 avail t+1", 32'(frame_avail), 32'd0);
    idle_cyc(1);
    chk("b1 ram_en off", 32'(ram_en),      32'd0);
    chk("b1 ram_we off", 32'(ram_we),      32'd0);
    chk("b1 avail t+2",  32'(frame_avail), 32'd1);
    chk("b1 slot",       32'(frame_slot),  32'd0);
    chk("b1 len",        32'(frame_len),   32'd1);
    ack_once();
    chk("b1 ack avail", 32'(frame_avail), 32'd0);
    chk("b1 ack slot",  32'(frame_slot),  32'd1);

    // 60-byte frame into slot 1
    clear_log();
    send_frame(60, 1'b0);
    idle_cyc(1);
    chk("f60 avail t+1", 32'(frame_avail), 32'd0);
    idle_cyc(1);
    chk("f60 writes", 32'(log_addr.size()), 32'd60);
    for (int i = 0; i < 60; i++) begin
      if (i < log_addr.size()) begin
        chk("f60 addr", 32'(log_addr[i]), 32'((1 << 10) | (i / 2)));
        chk("f60 we",   32'(log_we[i]),   (i % 2 == 1) ? 32'd2 : 32'd1);
        chk("f60 din",  32'(log_din[i]),  32'((i << 8) | i));
      end
    end
    chk("f60 avail", 32'(frame_avail), 32'd1);
    chk("f60 slot",  32'(frame_slot),  32'd1);
    chk("f60 len",   32'(frame_len),   32'd60);
    ack_once();
    chk("f60 ack avail", 32'(frame_avail), 32'd0);

    // Nine back-to-back 64-byte frames: slots 2..7,0,1 fill, ninth dropped
    clear_log();
    for (int f = 0; f < 9; f++) send_frame(64, 1'b0);
    idle_cyc(2);
    chk("full writes",   32'(log_addr.size()), 32'd512);
    chk("full drop_cnt", 32'(drop_cnt),        32'd1);
    chk("full err_cnt",  32'(err_cnt),         32'd0);
    if (log_addr.size() == 512)
      chk("full last addr", 32'(log_addr[511]), 32'((1 << 10) | 31));
    chk("full avail", 32'(frame_avail), 32'd1);
    chk("full slot",  32'(frame_slot),  32'd2);
    chk("full len",   32'(frame_len),   32'd64);
    ack_once();
    chk("full ack slot", 32'(frame_slot), 32'd3);
    clear_log();
    send_frame(64, 1'b0);
    idle_cyc(2);
    chk("tenth writes", 32'(log_addr.size()), 32'd64);
    if (log_addr.size() > 0)
      chk("tenth addr", 32'(log_addr[0]), 32'(2 << 10));
    chk("tenth drop_cnt", 32'(drop_cnt), 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("drain avail", 32'(frame_avail), 32'd1);
      chk("drain slot",  32'(frame_slot),  32'((3 + k) % 8));
      chk("drain len",   32'(frame_len),   32'd64);
      ack_once();
    end
    chk("drain empty", 32'(frame_avail), 32'd0);

    // Errored frame, then a good frame reusing slot 3
    send_frame(100, 1'b1);
    idle_cyc(2);
    chk("tuser err_cnt", 32'(err_cnt),     32'd1);
    chk("tuser avail",   32'(frame_avail), 32'd0);
    clear_log();
    send_frame(10, 1'b0);
    idle_cyc(2);
    if (log_addr.size() > 0)
      chk("reuse addr", 32'(log_addr[0]), 32'(3 << 10));
    chk("reuse slot", 32'(frame_slot), 32'd3);
    chk("reuse len",  32'(frame_len),  32'd10);
    ack_once();

    // Oversize 2049-byte frame
    clear_log();
    send_frame(2049, 1'b0);
    idle_cyc(2);
    chk("over writes",  32'(log_addr.size()), 32'd2048);
    chk("over err_cnt", 32'(err_cnt),         32'd2);
    chk("over avail",   32'(frame_avail),     32'd0);
    if (log_addr.size() == 2048) begin
      chk("over last addr", 32'(log_addr[2047]), 32'((4 << 10) | 1023));
      chk("over last we",   32'(log_we[2047]),   32'd2);
    end

    // Maximum 2048-byte frame
    clear_log();
    send_frame(2048, 1'b0);
    idle_cyc(2);
    chk("max writes", 32'(log_addr.size()), 32'd2048);
    chk("max avail",  32'(frame_avail),     32'd1);
    chk("max slot",   32'(frame_slot),      32'd4);
    chk("max len",    32'(frame_len),       32'd2048);

    // Ack in the same cycle as the commit of a 5-byte frame in slot 5
    send_frame(5, 1'b0);
    @(negedge clk);
    rx_tvalid = 1'b0; rx_tlast = 1'b0; frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    #1;
    chk("sim avail", 32'(frame_avail), 32'd1);
    chk("sim slot",  32'(frame_slot),  32'd5);
    chk("sim len",   32'(frame_len),   32'd5);
    idle_cyc(1);
    chk("sim avail hold", 32'(frame_avail), 32'd1);
    ack_once();
    chk("sim drained", 32'(frame_avail), 32'd0);
    chk("sim slot6",   32'(frame_slot),  32'd6);

    // Reset in the middle of a frame at byte 30
    for (int i = 0; i < 30; i++) send(8'(i), 1'b0, 1'b0);
    @(negedge clk);
    rx_tdata = 8'd30;
    #1 rst = 1'b1;
    #1;
    chk_zero("midrst");
    clear_log();
    @(negedge clk); rst = 1'b0;
    for (int i = 31; i < 60; i++) send(8'(i), i == 59, 1'b0);
    idle_cyc(2);
    chk("midrst tail writes", 32'(log_addr.size()), 32'd0);
    chk("midrst err_cnt",     32'(err_cnt),         32'd0);
    chk("midrst drop_cnt",    32'(drop_cnt),        32'd0);
    chk("midrst avail",       32'(frame_avail),     32'd0);
    send_frame(8, 1'b0);
    idle_cyc(2);
    chk("post writes", 32'(log_addr.size()), 32'd8);
    if (log_addr.size() > 0)
      chk("post addr", 32'(log_addr[0]), 32'd0);
    chk("post avail", 32'(frame_avail), 32'd1);
    chk("post slot",  32'(frame_slot),  32'd0);
    chk("post len",   32'(frame_len),   32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
